// File: rtl/spi_host_master.sv
// SPI mode-0 initiator for the client register chain: one 16-bit frame
// {rw, addr, data} per transaction, MSB first, all state in the SPI_CLK domain.
module spi_host_master #(
  parameter int DIV_HALF = 2
) (
  input  logic       SPI_CLK,
  input  logic       SPI_CLK_RESET_N,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       SCSN_toClient,
  output logic       SCLK_toClient,
  output logic       MOSI_toClient,
  input  logic       MISO_fromClient
);

  // state | meaning
  // IDLE  | waiting for start, chip select high
  // SETUP | SCSN low, SCLK low for one half-period before the first edge
  // XFER  | 16 SCLK periods, sample on rise, shift on fall
  // HOLD  | SCSN still low for one half-period after the last fall
  // GAP   | SCSN high for one half-period, then done pulse
  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  localparam logic [7:0] DIV_LOAD = 8'(DIV_HALF - 1);

  state_t      state, state_d;
  logic [7:0]  div_cnt;
  logic [3:0]  bit_cnt;
  logic [15:0] tx_sr, rx_sr, tx_next;
  logic        rw_q;
  logic        tc;
  logic        accept, sclk_rise, sclk_fall, xfer_end, hold_end, gap_end;

  assign tc      = (div_cnt == 8'd0);
  assign tx_next = {rw, addr, rw ? 8'h00 : wdata};

  always_ff @(posedge SPI_CLK or negedge SPI_CLK_RESET_N) begin
    if (!SPI_CLK_RESET_N) state <= IDLE;
    else                  state <= state_d;
  end

  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    sclk_rise = 1'b0;
    sclk_fall = 1'b0;
    xfer_end  = 1'b0;
    hold_end  = 1'b0;
    gap_end   = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept  = 1'b1;
        state_d = SETUP;
      end
      SETUP: if (tc) begin
        sclk_rise = 1'b1;
        state_d   = XFER;
      end
      XFER: if (tc) begin
        // SCLK itself tells which half of the bit period just ended
        if (SCLK_toClient)           sclk_fall = 1'b1;
        else if (bit_cnt == 4'd0) begin
          xfer_end = 1'b1;
          state_d  = HOLD;
        end else                     sclk_rise = 1'b1;
      end
      HOLD: if (tc) begin
        hold_end = 1'b1;
        state_d  = GAP;
      end
      GAP: if (tc) begin
        gap_end = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SPI_CLK or negedge SPI_CLK_RESET_N) begin
    if (!SPI_CLK_RESET_N) begin
      div_cnt       <= DIV_LOAD;
      bit_cnt       <= 4'd0;
      tx_sr         <= 16'h0000;
      rx_sr         <= 16'h0000;
      rw_q          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rdata         <= 8'h00;
      SCSN_toClient <= 1'b1;
      SCLK_toClient <= 1'b0;
      MOSI_toClient <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE || tc) div_cnt <= DIV_LOAD;
      else                     div_cnt <= div_cnt - 8'd1;

      if (accept) begin
        rw_q          <= rw;
        tx_sr         <= tx_next;
        busy          <= 1'b1;
        SCSN_toClient <= 1'b0;
        MOSI_toClient <= tx_next[15];
      end
      if (sclk_rise) begin
        SCLK_toClient <= 1'b1;
        rx_sr         <= {rx_sr[14:0], MISO_fromClient};
        bit_cnt       <= (state == SETUP) ? 4'd15 : bit_cnt - 4'd1;
      end
      if (sclk_fall) begin
        SCLK_toClient <= 1'b0;
        tx_sr         <= {tx_sr[14:0], 1'b0};
        MOSI_toClient <= tx_sr[14];
      end
      if (xfer_end) MOSI_toClient <= 1'b0;
      if (hold_end) begin
        SCSN_toClient <= 1'b1;
        if (rw_q) rdata <= rx_sr[7:0];
      end
      if (gap_end) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_host_master.sv
// Directed bench for spi_host_master: one DUT at DIV_HALF=2 with a mode-0
// client model, plus a DIV_HALF=1 build whose MISO is tied high.
module tb_spi_host_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy, done, scsn, sclk, mosi, miso;
  logic [7:0] rdata;

  logic       start2;
  logic       busy2, done2, scsn2, sclk2, mosi2;
  logic [7:0] rdata2;

  int errors = 0;
  int checks = 0;

  // per-run observations
  int          f_busy, f_scsn, f_rises, f_dones, f_gap, hi_run, bidx;
  logic [15:0] f_mosi, pat;
  logic [7:0]  f_rdata;
  logic        prev_scsn, prev_sclk, seen_low;

  always #5 clk = ~clk;

  spi_host_master #(.DIV_HALF(2)) dut (
    .SPI_CLK(clk), .SPI_CLK_RESET_N(rst_n), .start(start), .rw(rw), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .SCSN_toClient(scsn), .SCLK_toClient(sclk), .MOSI_toClient(mosi),
    .MISO_fromClient(miso));

  spi_host_master #(.DIV_HALF(1)) dut1 (
    .SPI_CLK(clk), .SPI_CLK_RESET_N(rst_n), .start(start2), .rw(1'b1), .addr(7'h7F),
    .wdata(8'h00), .busy(busy2), .done(done2), .rdata(rdata2),
    .SCSN_toClient(scsn2), .SCLK_toClient(sclk2), .MOSI_toClient(mosi2),
    .MISO_fromClient(1'b1));

  task automatic clear_obs();
    f_busy = 0; f_scsn = 0; f_rises = 0; f_dones = 0; f_gap = -1; hi_run = 0;
    f_mosi = 16'h0; f_rdata = 8'hxx; seen_low = 1'b0; bidx = -1;
    prev_scsn = scsn; prev_sclk = sclk;
  endtask

  // one negedge sample of the DIV_HALF=2 DUT, acting as the client too
  task automatic sample();
    if (busy) f_busy++;
    if (!scsn) f_scsn++;
    if (done) begin f_dones++; f_rdata = rdata; end
    if (scsn) hi_run++;
    else begin
      if (hi_run > 0 && seen_low) f_gap = hi_run;
      hi_run = 0; seen_low = 1'b1;
    end
    if (!prev_sclk && sclk) begin f_mosi = {f_mosi[14:0], mosi}; f_rises++; end
    if (prev_scsn && !scsn) begin miso = pat[15]; bidx = 14; end
    if (prev_sclk && !sclk && bidx >= 0) begin miso = pat[bidx]; bidx--; end
    prev_scsn = scsn; prev_sclk = sclk;
  endtask

  task automatic run_frames(input logic r, input logic [6:0] a, input logic [7:0] w,
                            input logic [15:0] p, input int nframes, input bit hold,
                            input int pulse_at);
    pat = p;
    clear_obs();
    @(negedge clk);
    rw = r; addr = a; wdata = w; start = 1'b1;
    for (int i = 0; i < 300 * nframes; i++) begin
      @(negedge clk);
      if (!hold) start = (i == pulse_at);
      sample();
      if (f_dones == nframes) begin start = 1'b0; break; end
    end
    start = 1'b0;
    if (f_dones != nframes) begin
      errors++;
      $display("FAIL timeout: dones=%0d required %0d", f_dones, nframes);
    end
    checks++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; rw = 1'b0; addr = 7'h0; wdata = 8'h0;
    miso = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks += 6;
    if (scsn !== 1'b1) begin errors++; $display("FAIL reset_scsn: got %b want 1", scsn); end
    if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", mosi); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", rdata); end
  endtask

  task automatic test_reset_mid_frame();
    pat = 16'hFFFF;
    clear_obs();
    @(negedge clk);
    rw = 1'b1; addr = 7'h55; wdata = 8'h00; start = 1'b1;
    for (int i = 0; i < 200 && f_rises < 5; i++) begin
      @(negedge clk);
      start = 1'b0;
      sample();
    end
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (scsn !== 1'b1) begin errors++; $display("FAIL midrst_scsn: got %b want 1", scsn); end
    if (sclk !== 1'b0) begin errors++; $display("FAIL midrst_sclk: got %b want 0", sclk); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    if (rdata !== 8'h00) begin errors++; $display("FAIL midrst_rdata: got %h want 00", rdata); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_frames(1'b0, 7'h2A, 8'h3C, 16'h0000, 1, 1'b0, -1);
    checks += 2;
    if (f_rises != 16) begin errors++; $display("FAIL midrst_rises: got %0d want 16", f_rises); end
    if (f_mosi !== 16'h2A3C) begin errors++; $display("FAIL midrst_mosi: got %h want 2a3c", f_mosi); end
  endtask

  task automatic test_write();
    run_frames(1'b0, 7'h15, 8'hA5, 16'hFFFF, 1, 1'b0, -1);
    checks += 6;
    if (f_mosi !== 16'h15A5) begin errors++; $display("FAIL write_mosi: got %h want 15a5", f_mosi); end
    if (f_rises != 16) begin errors++; $display("FAIL write_rises: got %0d want 16", f_rises); end
    if (f_busy != 70) begin errors++; $display("FAIL write_busy_cycles: got %0d want 70", f_busy); end
    if (f_scsn != 68) begin errors++; $display("FAIL write_scsn_cycles: got %0d want 68", f_scsn); end
    if (f_dones != 1) begin errors++; $display("FAIL write_dones: got %0d want 1", f_dones); end
    if (f_rdata !== 8'h00) begin errors++; $display("FAIL write_rdata: got %h want 00", f_rdata); end
  endtask

  task automatic test_read();
    run_frames(1'b1, 7'h03, 8'hFF, 16'hA53C, 1, 1'b0, -1);
    checks += 3;
    if (f_mosi !== 16'h8300) begin errors++; $display("FAIL read_mosi: got %h want 8300", f_mosi); end
    if (f_rdata !== 8'h3C) begin errors++; $display("FAIL read_rdata: got %h want 3c", f_rdata); end
    if (f_busy != 70) begin errors++; $display("FAIL read_busy_cycles: got %0d want 70", f_busy); end
    @(negedge clk);
    checks++;
    if (rdata !== 8'h3C) begin errors++; $display("FAIL read_rdata_hold: got %h want 3c", rdata); end
  endtask

  task automatic test_read_discard();
    run_frames(1'b1, 7'h40, 8'h00, 16'hFF00, 1, 1'b0, -1);
    checks += 2;
    if (f_rdata !== 8'h00) begin errors++; $display("FAIL discard_rdata: got %h want 00", f_rdata); end
    if (f_mosi !== 16'hC000) begin errors++; $display("FAIL discard_mosi: got %h want c000", f_mosi); end
  endtask

  task automatic test_back_to_back();
    run_frames(1'b0, 7'h11, 8'h22, 16'h0000, 3, 1'b1, -1);
    checks += 4;
    if (f_dones != 3) begin errors++; $display("FAIL b2b_dones: got %0d want 3", f_dones); end
    if (f_rises != 48) begin errors++; $display("FAIL b2b_rises: got %0d want 48", f_rises); end
    // deselect between frames: GAP half-period plus the done cycle
    if (f_gap != 3) begin errors++; $display("FAIL b2b_gap: got %0d want 3", f_gap); end
    if (f_busy != 210) begin errors++; $display("FAIL b2b_busy_cycles: got %0d want 210", f_busy); end
  endtask

  task automatic test_ignore_start();
    run_frames(1'b0, 7'h7E, 8'h81, 16'h0000, 1, 1'b0, 20);
    repeat (80) begin @(negedge clk); sample(); end
    checks += 3;
    if (f_dones != 1) begin errors++; $display("FAIL ignore_dones: got %0d want 1", f_dones); end
    if (f_rises != 16) begin errors++; $display("FAIL ignore_rises: got %0d want 16", f_rises); end
    if (f_mosi !== 16'h7E81) begin errors++; $display("FAIL ignore_mosi: got %h want 7e81", f_mosi); end
  endtask

  task automatic test_div1();
    int nb, nr, nd, r1, r2, cyc;
    logic ps;
    logic [7:0] rd;
    nb = 0; nr = 0; nd = 0; r1 = -1; r2 = -1; ps = sclk2; rd = 8'hxx;
    @(negedge clk);
    start2 = 1'b1;
    for (cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (busy2) nb++;
      if (!ps && sclk2) begin
        nr++;
        if (r1 < 0) r1 = cyc; else if (r2 < 0) r2 = cyc;
      end
      if (done2) begin nd++; rd = rdata2; end
      ps = sclk2;
    end
    checks += 5;
    if (nb != 35) begin errors++; $display("FAIL div1_busy_cycles: got %0d want 35", nb); end
    if (nr != 16) begin errors++; $display("FAIL div1_rises: got %0d want 16", nr); end
    if (r2 - r1 != 2) begin errors++; $display("FAIL div1_period: got %0d want 2", r2 - r1); end
    if (nd != 1) begin errors++; $display("FAIL div1_dones: got %0d want 1", nd); end
    if (rd !== 8'hFF) begin errors++; $display("FAIL div1_rdata: got %h want ff", rd); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_write();
    test_read();
    test_read_discard();
    test_back_to_back();
    test_ignore_start();
    test_div1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
